// File: rtl/mp3_resp_parser_if.sv
// Byte-in / frame-out bundle between the UART RX stage, the reply parser and playback control.
interface mp3_resp_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic [15:0] param;
  logic [1:0]  plen;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  // Byte source side (UART RX stage or testbench).
  modport master (
    output rx_data,
    output rx_valid,
    input  frame_valid,
    input  cmd,
    input  param,
    input  plen,
    input  err,
    input  err_code,
    input  busy
  );

  // Parser side.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output frame_valid,
    output cmd,
    output param,
    output plen,
    output err,
    output err_code,
    output busy
  );
endinterface

// File: rtl/mp3_resp_parser.sv
// Parses 7E/LEN/CMD/params/EF reply frames from the MP3 player and reports good frames or errors.
module mp3_resp_parser #(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned MAX_LEN     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mp3_resp_parser_if.slave   bus
);

  localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] ByteSof = 8'h7E;
  localparam logic [7:0] ByteEof = 8'hEF;
  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StLen, StCmd, StPar, StEnd} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        len_q, len_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_r_q, cmd_r_d;
  logic [15:0]       param_r_q, param_r_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [15:0]       param_q, param_d;
  logic [1:0]        plen_q, plen_d;
  logic              frame_valid_q, frame_valid_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [2:0] len_m2;
  logic [2:0] cnt_next;

  assign len_m2   = len_q - 3'd2;
  assign cnt_next = {1'b0, cnt_q} + 3'd1;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      cmd_r_q       <= '0;
      param_r_q     <= '0;
      cmd_q         <= '0;
      param_q       <= '0;
      plen_q        <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      cmd_r_q       <= cmd_r_d;
      param_r_q     <= param_r_d;
      cmd_q         <= cmd_d;
      param_q       <= param_d;
      plen_q        <= plen_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  // Next-state: byte-driven frame walk plus inter-byte timeout.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    cmd_r_d       = cmd_r_q;
    param_r_d     = param_r_q;
    cmd_d         = cmd_q;
    param_d       = param_q;
    plen_d        = plen_q;
    frame_valid_d = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;

    if (bus.rx_valid) begin
      // A byte always wins over a same-cycle expiry.
      timer_d = '0;
      unique case (state_q)
        StIdle: begin
          if (bus.rx_data == ByteSof) state_d = StLen;
        end
        StLen: begin
          if (bus.rx_data >= 8'd2 && bus.rx_data <= MaxLenB) begin
            len_d   = bus.rx_data[2:0];
            state_d = StCmd;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            state_d    = StIdle;
          end
        end
        StCmd: begin
          cmd_r_d   = bus.rx_data;
          param_r_d = '0;
          cnt_d     = '0;
          state_d   = (len_q > 3'd2) ? StPar : StEnd;
        end
        StPar: begin
          param_r_d = {param_r_q[7:0], bus.rx_data};
          cnt_d     = cnt_next[1:0];
          if (cnt_next == len_m2) state_d = StEnd;
        end
        StEnd: begin
          if (bus.rx_data == ByteEof) begin
            cmd_d         = cmd_r_q;
            param_d       = param_r_q;
            plen_d        = len_m2[1:0];
            frame_valid_d = 1'b1;
            state_d       = StIdle;
          end else begin
            // Offending byte is re-examined as an IDLE byte so a 7E resyncs at once.
            err_d      = 1'b1;
            err_code_d = 2'd2;
            state_d    = (bus.rx_data == ByteSof) ? StLen : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIdle) begin
      timer_d = '0;
    end else if (timer_q == TimerLast) begin
      err_d      = 1'b1;
      err_code_d = 2'd3;
      state_d    = StIdle;
      timer_d    = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Drive registered results onto the bus.
  always_comb begin
    bus.frame_valid = frame_valid_q;
    bus.cmd         = cmd_q;
    bus.param       = param_q;
    bus.plen        = plen_q;
    bus.err         = err_q;
    bus.err_code    = err_code_q;
    bus.busy        = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mp3_resp_parser.sv
// Directed bench for the MP3 reply-frame parser.
module tb_mp3_resp_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   fv_seen = 0;
  int   err_seen = 0;
  int   both_seen = 0;

  mp3_resp_parser_if bus ();

  mp3_resp_parser #(
    .TIMEOUT_CYC (100),
    .MAX_LEN     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_seen++;
    if (bus.err === 1'b1) err_seen++;
    if (bus.frame_valid === 1'b1 && bus.err === 1'b1) both_seen++;
  end

  // Presents one byte for one cycle; returns 1 ns after the sampling edge.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    idle(2);
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", bus.frame_valid); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
    total++; if (bus.cmd !== 8'h00) begin bad++; $display("FAIL reset_cmd got=%h want=00", bus.cmd); end
    total++; if (bus.param !== 16'h0000) begin bad++; $display("FAIL reset_param got=%h want=0000", bus.param); end
    total++; if (bus.plen !== 2'd0) begin bad++; $display("FAIL reset_plen got=%0d want=0", bus.plen); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", bus.err_code); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    #2 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    send(8'h7E); send(8'h04); send(8'h45); send(8'h00); send(8'h01);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid got=%b want=1", bus.busy); end
    send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv got=%b want=1", bus.frame_valid); end
    total++; if (bus.cmd !== 8'h45) begin bad++; $display("FAIL basic_cmd got=%h want=45", bus.cmd); end
    total++; if (bus.param !== 16'h0001) begin bad++; $display("FAIL basic_param got=%h want=0001", bus.param); end
    total++; if (bus.plen !== 2'd2) begin bad++; $display("FAIL basic_plen got=%0d want=2", bus.plen); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", bus.busy); end
    idle(1);
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_pulse got=%b want=0", bus.frame_valid); end
    total++; if (bus.cmd !== 8'h45) begin bad++; $display("FAIL basic_cmd_hold got=%h want=45", bus.cmd); end
  endtask

  task automatic test_short_frames;
    send(8'h7E); send(8'h02); send(8'h01); send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL len2_fv got=%b want=1", bus.frame_valid); end
    total++; if (bus.cmd !== 8'h01) begin bad++; $display("FAIL len2_cmd got=%h want=01", bus.cmd); end
    total++; if (bus.param !== 16'h0000) begin bad++; $display("FAIL len2_param got=%h want=0000", bus.param); end
    total++; if (bus.plen !== 2'd0) begin bad++; $display("FAIL len2_plen got=%0d want=0", bus.plen); end
    idle(1);
    send(8'h7E); send(8'h03); send(8'h3D); send(8'h05); send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL len3_fv got=%b want=1", bus.frame_valid); end
    total++; if (bus.cmd !== 8'h3D) begin bad++; $display("FAIL len3_cmd got=%h want=3d", bus.cmd); end
    total++; if (bus.param !== 16'h0005) begin bad++; $display("FAIL len3_param got=%h want=0005", bus.param); end
    total++; if (bus.plen !== 2'd1) begin bad++; $display("FAIL len3_plen got=%0d want=1", bus.plen); end
    idle(1);
  endtask

  task automatic test_bad_len;
    int fv0;
    int er0;
    fv0 = fv_seen;
    er0 = err_seen;
    send(8'h55);
    idle(1);
    total++; if (err_seen !== er0) begin bad++; $display("FAIL junk_no_err got=%0d want=%0d", err_seen, er0); end
    send(8'h7E); send(8'h05);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL badlen_err got=%b want=1", bus.err); end
    total++; if (bus.err_code !== 2'd1) begin bad++; $display("FAIL badlen_code got=%0d want=1", bus.err_code); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL badlen_fv got=%b want=0", bus.frame_valid); end
    total++; if (bus.cmd !== 8'h3D) begin bad++; $display("FAIL badlen_cmd got=%h want=3d", bus.cmd); end
    total++; if (bus.param !== 16'h0005) begin bad++; $display("FAIL badlen_param got=%h want=0005", bus.param); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL badlen_busy got=%b want=0", bus.busy); end
    idle(1);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL badlen_err_pulse got=%b want=0", bus.err); end
    total++; if (bus.err_code !== 2'd1) begin bad++; $display("FAIL badlen_code_hold got=%0d want=1", bus.err_code); end
    total++; if (fv_seen !== fv0) begin bad++; $display("FAIL badlen_no_fv got=%0d want=%0d", fv_seen, fv0); end
    // Zero length is illegal too.
    send(8'h7E); send(8'h00);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL len0_err got=%b want=1", bus.err); end
    idle(1);
    send(8'h7E); send(8'h03); send(8'h10); send(8'hAA); send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL after_bad_fv got=%b want=1", bus.frame_valid); end
    total++; if (bus.cmd !== 8'h10) begin bad++; $display("FAIL after_bad_cmd got=%h want=10", bus.cmd); end
    total++; if (bus.param !== 16'h00AA) begin bad++; $display("FAIL after_bad_param got=%h want=00aa", bus.param); end
    idle(1);
  endtask

  task automatic test_missing_ef;
    send(8'h7E); send(8'h04); send(8'h45); send(8'h00); send(8'h01); send(8'h7E);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL noef_err got=%b want=1", bus.err); end
    total++; if (bus.err_code !== 2'd2) begin bad++; $display("FAIL noef_code got=%0d want=2", bus.err_code); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL noef_resync_busy got=%b want=1", bus.busy); end
    total++; if (bus.cmd !== 8'h10) begin bad++; $display("FAIL noef_cmd_kept got=%h want=10", bus.cmd); end
    send(8'h02); send(8'h01); send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL noef_fv got=%b want=1", bus.frame_valid); end
    total++; if (bus.cmd !== 8'h01) begin bad++; $display("FAIL noef_cmd got=%h want=01", bus.cmd); end
    total++; if (bus.plen !== 2'd0) begin bad++; $display("FAIL noef_plen got=%0d want=0", bus.plen); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    int fv0;
    fv0 = fv_seen;
    // 7E and EF as parameter data, then a second frame with no gap.
    send(8'h7E); send(8'h04); send(8'h12); send(8'h7E); send(8'hEF); send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_fv1 got=%b want=1", bus.frame_valid); end
    total++; if (bus.param !== 16'h7EEF) begin bad++; $display("FAIL b2b_param1 got=%h want=7eef", bus.param); end
    total++; if (bus.cmd !== 8'h12) begin bad++; $display("FAIL b2b_cmd1 got=%h want=12", bus.cmd); end
    send(8'h7E); send(8'h02); send(8'h09); send(8'hEF);
    total++; if (bus.cmd !== 8'h09) begin bad++; $display("FAIL b2b_cmd2 got=%h want=09", bus.cmd); end
    total++; if (bus.param !== 16'h0000) begin bad++; $display("FAIL b2b_param2 got=%h want=0000", bus.param); end
    idle(1);
    total++; if (fv_seen !== fv0 + 2) begin bad++; $display("FAIL b2b_fv_count got=%0d want=%0d", fv_seen, fv0 + 2); end
  endtask

  task automatic test_timeout;
    int er0;
    send(8'h7E); send(8'h04); send(8'h45);
    idle(99);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", bus.err); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL to_busy_before got=%b want=1", bus.busy); end
    idle(1);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", bus.err); end
    total++; if (bus.err_code !== 2'd3) begin bad++; $display("FAIL to_code got=%0d want=3", bus.err_code); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_busy_after got=%b want=0", bus.busy); end
    idle(2);
    // Byte lands in the very cycle the timer would expire.
    er0 = err_seen;
    send(8'h7E); send(8'h04); send(8'h45);
    idle(99);
    bus.rx_data = 8'h00; bus.rx_valid = 1'b1; @(posedge clk); #1; bus.rx_valid = 1'b0;
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL to_race_err got=%b want=0", bus.err); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL to_race_busy got=%b want=1", bus.busy); end
    send(8'h01); send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL to_race_fv got=%b want=1", bus.frame_valid); end
    total++; if (bus.param !== 16'h0001) begin bad++; $display("FAIL to_race_param got=%h want=0001", bus.param); end
    total++; if (err_seen !== er0) begin bad++; $display("FAIL to_race_errcount got=%0d want=%0d", err_seen, er0); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    int fv0;
    int er0;
    send(8'h7E); send(8'h04); send(8'h45);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.cmd !== 8'h00) begin bad++; $display("FAIL rmid_cmd got=%h want=00", bus.cmd); end
    total++; if (bus.param !== 16'h0000) begin bad++; $display("FAIL rmid_param got=%h want=0000", bus.param); end
    total++; if (bus.plen !== 2'd0) begin bad++; $display("FAIL rmid_plen got=%0d want=0", bus.plen); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL rmid_code got=%0d want=0", bus.err_code); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
    idle(1);
    #2 rst_n = 1'b1;
    idle(1);
    fv0 = fv_seen;
    er0 = err_seen;
    send(8'h00); send(8'h01); send(8'hEF);
    idle(2);
    total++; if (fv_seen !== fv0) begin bad++; $display("FAIL rmid_no_fv got=%0d want=%0d", fv_seen, fv0); end
    total++; if (err_seen !== er0) begin bad++; $display("FAIL rmid_no_err got=%0d want=%0d", err_seen, er0); end
    send(8'h7E); send(8'h04); send(8'hA5); send(8'h12); send(8'h34); send(8'hEF);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL rmid_fv got=%b want=1", bus.frame_valid); end
    total++; if (bus.cmd !== 8'hA5) begin bad++; $display("FAIL rmid_after_cmd got=%h want=a5", bus.cmd); end
    total++; if (bus.param !== 16'h1234) begin bad++; $display("FAIL rmid_after_param got=%h want=1234", bus.param); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frames();
    test_bad_len();
    test_missing_ef();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    total++; if (both_seen !== 0) begin bad++; $display("FAIL fv_err_overlap got=%0d want=0", both_seen); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
